// File: rtl/alu_mult_ctrl_pkg.sv
// alu_mult_ctrl_pkg: ALU op encodings, FSM state codes and the default operand width.
package alu_mult_ctrl_pkg;
    localparam int DEFAULT_WIDTH = 32;
    typedef enum logic [3:0] {
        ALUOP_AND = 4'b0000,
        ALUOP_OR  = 4'b0001,
        ALUOP_ADD = 4'b0010,
        ALUOP_SUB = 4'b0110,
        ALUOP_SLT = 4'b0111,
        ALUOP_NOR = 4'b1100
    } alu_op_t;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/alu_mult_ctrl_if.sv
// alu_mult_ctrl_if: request/result handshake plus the borrowed-ALU operand/result bus.
interface alu_mult_ctrl_if #(parameter int WIDTH = 32);
    logic                 start;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 ready;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [3:0]           alu_op;
    logic [WIDTH-1:0]     alu_result;
    logic                 alu_cout;
    modport master (
        output start, mcand, mplier, alu_result, alu_cout,
        input  ready, done, product, alu_a, alu_b, alu_op
    );
    modport slave (
        input  start, mcand, mplier, alu_result, alu_cout,
        output ready, done, product, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_mult_ctrl_mult_iter_counter.sv
// mult_iter_counter: shift-add iteration counter with terminal count at WIDTH-1.
module mult_iter_counter #(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + CW'(1);
    end
    assign tc = (cnt == CW'(WIDTH - 1));
endmodule

// File: rtl/alu_mult_ctrl.sv
// alu_mult_ctrl: unsigned shift-add multiplier that performs every addition on an external ALU.
module alu_mult_ctrl
    import alu_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic            clk,
    input logic            rst_n,
    alu_mult_ctrl_if.slave bus
);
    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   p, product;
    logic [WIDTH-1:0]     m;
    logic                 done, ready, accept, tc;
    // ready stays low through the done cycle so a held start is taken one cycle later
    assign ready  = (state == ST_IDLE) && !done;
    assign accept = ready && bus.start;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == ST_IDLE && accept) ? ST_RUN :
                    (state == ST_RUN && tc)      ? ST_DONE :
                    (state == ST_DONE)           ? ST_IDLE : state;
    end
    always_comb begin
        bus.ready  = ready;
        bus.alu_op = (state == ST_RUN) ? ALUOP_ADD : ALUOP_AND;
        bus.alu_a  = (state == ST_RUN) ? p[2*WIDTH-1:WIDTH] : '0;
        bus.alu_b  = (state == ST_RUN) ? m : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p       <= '0;
            m       <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == ST_DONE);
            if (accept) begin
                p <= {{WIDTH{1'b0}}, bus.mplier};
                m <= bus.mcand;
            end else if (state == ST_RUN) begin
                p <= p[0] ? {bus.alu_cout, bus.alu_result, p[WIDTH-1:1]} : {1'b0, p[2*WIDTH-1:1]};
            end
            if (state == ST_DONE) product <= p;
        end
    end
    mult_iter_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != ST_RUN),
        .enable (state == ST_RUN),
        .tc     (tc)
    );
    assign bus.done    = done;
    assign bus.product = product;
endmodule

// File: tb/tb_alu_mult_ctrl.sv
// tb_alu_mult_ctrl: directed and random multiplies against an arithmetic reference and a bench-side ALU.
module tb_alu_mult_ctrl;
    import alu_mult_ctrl_pkg::*;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    alu_mult_ctrl_if #(.WIDTH(W)) bus ();
    alu_mult_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    logic [W:0] sum;
    always_comb begin
        sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result = (bus.alu_op == ALUOP_ADD) ? sum[W-1:0] :
                         (bus.alu_op == ALUOP_AND) ? (bus.alu_a & bus.alu_b) : '0;
        bus.alu_cout   = (bus.alu_op == ALUOP_ADD) ? sum[W] : 1'b0;
    end
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_ready_wait"}, 64'(bus.ready), 64'd1);
    endtask
    task automatic check_idle_outputs(input string tag, input logic [63:0] prod);
        chk({tag, "_ready"}, 64'(bus.ready), 64'd1);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_product"}, bus.product, prod);
        chk({tag, "_alu_op"}, 64'(bus.alu_op), 64'(ALUOP_AND));
        chk({tag, "_alu_a"}, 64'(bus.alu_a), 64'd0);
        chk({tag, "_alu_b"}, 64'(bus.alu_b), 64'd0);
    endtask
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [63:0] exp;
        int adds;
        int dat;
        int d0;
        exp = 64'(a) * 64'(b);
        adds = 0;
        dat = -1;
        wait_ready(tag);
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.mcand = a;
        bus.mplier = b;
        tick();
        bus.start = 1'b0;
        bus.mcand = $urandom;
        bus.mplier = $urandom;
        for (int i = 0; i < 34; i++) begin
            if (bus.alu_op === ALUOP_ADD) adds++;
            if (bus.done === 1'b1 && dat < 0) dat = i;
            tick();
        end
        chk({tag, "_latency"}, 64'(dat), 64'd33);
        chk({tag, "_add_cycles"}, 64'(adds), 64'd32);
        chk({tag, "_product"}, bus.product, exp);
        chk({tag, "_ready_after"}, 64'(bus.ready), 64'd1);
        chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    endtask
    initial begin
        logic [63:0] prev;
        int d0;
        int first_done;
        int second_done;
        logic [63:0] p_first;
        logic [63:0] p_mid;
        logic [63:0] p_second;
        bus.start = 1'b0;
        bus.mcand = '0;
        bus.mplier = '0;
        #12;
        check_idle_outputs("reset", 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_mult(32'd3, 32'd5, "m3x5");
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
        run_mult(32'h1234_5678, 32'd0, "zero");
        // starts during RUN and the done cycle must be dropped
        wait_ready("ign");
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.mcand = 32'd9;
        bus.mplier = 32'd11;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.start = (i == 5 || bus.done === 1'b1) ? 1'b1 : 1'b0;
            bus.mcand = 32'd100 + 32'(i);
            bus.mplier = 32'd7;
            tick();
        end
        bus.start = 1'b0;
        chk("ign_product", bus.product, 64'd99);
        chk("ign_done_count", 64'(done_cnt - d0), 64'd1);
        chk("ign_still_idle_op", 64'(bus.alu_op), 64'(ALUOP_AND));
        // asynchronous reset in the middle of RUN
        prev = bus.product;
        chk("abort_prev_nonzero", 64'(prev != 0), 64'd1);
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.mcand = 32'd1000;
        bus.mplier = 32'd1000;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        chk("abort_running", 64'(bus.alu_op), 64'(ALUOP_ADD));
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("abort", 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) tick();
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_mult(32'd7, 32'd6, "m7x6");
        // start held high across two back-to-back operations
        wait_ready("b2b");
        d0 = done_cnt;
        first_done = -1;
        second_done = -1;
        p_first = '0;
        p_mid = '0;
        p_second = '0;
        bus.start = 1'b1;
        bus.mcand = 32'd2;
        bus.mplier = 32'd3;
        tick();
        bus.mcand = 32'd4;
        bus.mplier = 32'd5;
        for (int i = 0; i < 80 && second_done < 0; i++) begin
            if (bus.done === 1'b1) begin
                if (first_done < 0) begin
                    first_done = i;
                    p_first = bus.product;
                end else begin
                    second_done = i;
                    p_second = bus.product;
                    bus.start = 1'b0;
                end
            end
            if (i == 50) p_mid = bus.product;
            tick();
        end
        bus.start = 1'b0;
        chk("b2b_first_latency", 64'(first_done), 64'd33);
        chk("b2b_gap", 64'(second_done - first_done), 64'd35);
        chk("b2b_first_product", p_first, 64'd6);
        chk("b2b_mid_product", p_mid, 64'd6);
        chk("b2b_second_product", p_second, 64'd20);
        repeat (40) tick();
        chk("b2b_done_count", 64'(done_cnt - d0), 64'd2);
        for (int r = 0; r < 6; r++) run_mult($urandom, $urandom, $sformatf("rand%0d", r));
        run_mult(32'h8000_0000, 32'h8000_0001, "msb");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
